unit_splitter: RTL and testbench

Routes one 1024-bit data stream to either the buffer or the matrix unit. It is the distribution-side counterpart of the buffer/matrix input select.
- A controller issues a burst command with a destination and a beat count.
- The block accepts that many beats over a valid/ready input and forwards each beat to the selected destination through one registered slot.
- It pulses done when the last beat has been delivered.

---
 rtl/unit_pkg.sv | 17 +
 rtl/unit_pipe_slot.sv | 35 +++
 rtl/unit_splitter.sv | 113 +++++++++++
 tb/tb_unit_splitter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/unit_pkg.sv
// Shared constants and state encoding for the buffer/matrix stream splitter.
package unit_pkg;

  localparam int DEF_DATA_W = 1024;
  localparam int DEF_LEN_W  = 8;

  localparam logic SEL_BUFFER = 1'b1;
  localparam logic SEL_MATRIX = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/unit_pipe_slot.sv
// Single-entry valid/ready pipeline register; reloads in the same cycle it drains,
// so it sustains one beat per clock while the consumer is ready.
module unit_pipe_slot #(
  parameter int DATA_W = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data
);

  logic              r_full;
  logic [DATA_W-1:0] r_data;

  assign o_ready = !r_full || i_ready;
  assign o_valid = r_full;
  assign o_data  = r_data;

  // NOTE: the data register is reset as well, because consumers expect the
  // output bus to read zero after reset; <= keeps every flop sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (o_ready) begin
      r_full <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end

endmodule

// File: rtl/unit_splitter.sv
// Burst-driven stream splitter: forwards a commanded number of beats to either
// the buffer or the matrix unit through one registered slot, then pulses done.
module unit_splitter
  import unit_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              selector,
  input  logic [LEN_W-1:0]  burstLen,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [DATA_W-1:0] datsIn,
  input  logic              inValid,
  output logic              inReady,
  output logic [DATA_W-1:0] out_buffer,
  output logic              bufValid,
  input  logic              bufReady,
  output logic [DATA_W-1:0] out_matrix,
  output logic              matValid,
  input  logic              matReady
);

  state_t             r_state;
  logic               r_sel_lat;
  logic [LEN_W-1:0]   r_remaining;
  logic               r_busy;
  logic               r_done;

  logic               w_dest_ready;
  logic               w_slot_ready;
  logic               w_slot_full;
  logic [DATA_W-1:0]  w_slot_data;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_slot_handshake;

  assign w_dest_ready     = (r_sel_lat == SEL_BUFFER) ? bufReady : matReady;
  assign w_accept         = inValid && w_in_ready;
  assign w_slot_handshake = w_slot_full && w_dest_ready;

  // NOTE: every variable assigned here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_in_ready = 1'b0;
    if (r_state == ST_RUN && r_remaining != '0) w_in_ready = w_slot_ready;
  end

  unit_pipe_slot #(.DATA_W(DATA_W)) u_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_accept),
    .o_ready (w_slot_ready),
    .i_data  (datsIn),
    .o_valid (w_slot_full),
    .i_ready (w_dest_ready),
    .o_data  (w_slot_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_sel_lat   <= SEL_MATRIX;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (burstLen != '0) begin
              r_sel_lat   <= selector;
              r_remaining <= burstLen;
              r_busy      <= 1'b1;
              r_state     <= ST_RUN;
            end else begin
              // Empty burst completes immediately without ever going busy.
              r_done <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            r_remaining <= r_remaining - LEN_W'(1);
            if (r_remaining == LEN_W'(1)) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!w_slot_full || w_slot_handshake) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign inReady    = w_in_ready;
  assign out_buffer = w_slot_data;
  assign out_matrix = w_slot_data;
  assign bufValid   = w_slot_full && (r_sel_lat == SEL_BUFFER);
  assign matValid   = w_slot_full && (r_sel_lat == SEL_MATRIX);

endmodule

// File: tb/tb_unit_splitter.sv
// Directed bench for unit_splitter: one task per scenario with inline checks.
module tb_unit_splitter;
  import unit_pkg::*;

  localparam int DATA_W = DEF_DATA_W;
  localparam int LEN_W  = DEF_LEN_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              selector;
  logic [LEN_W-1:0]  burstLen;
  logic              start;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] datsIn;
  logic              inValid;
  logic              inReady;
  logic [DATA_W-1:0] out_buffer;
  logic              bufValid;
  logic              bufReady;
  logic [DATA_W-1:0] out_matrix;
  logic              matValid;
  logic              matReady;

  logic [4:0] flags;
  assign flags = {busy, done, inReady, bufValid, matValid};

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  unit_splitter #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .selector   (selector),
    .burstLen   (burstLen),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .datsIn     (datsIn),
    .inValid    (inValid),
    .inReady    (inReady),
    .out_buffer (out_buffer),
    .bufValid   (bufValid),
    .bufReady   (bufReady),
    .out_matrix (out_matrix),
    .matValid   (matValid),
    .matReady   (matReady)
  );

  function automatic logic [DATA_W-1:0] beat(input logic [31:0] tag);
    return {32{tag}};
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) begin
      start    = 1'($urandom);
      selector = 1'($urandom);
      burstLen = LEN_W'($urandom);
      inValid  = 1'($urandom);
      datsIn   = {32{$urandom}};
      bufReady = 1'($urandom);
      matReady = 1'($urandom);
      @(posedge clk);
    end
    #1;
    n_vec++; if (flags !== 5'b00000) begin n_err++; $display("FAIL reset_flags: got %b want 00000", flags); end
    n_vec++; if (out_buffer !== '0) begin n_err++; $display("FAIL reset_out_buffer: got %h want 0", out_buffer[31:0]); end
    n_vec++; if (out_matrix !== '0) begin n_err++; $display("FAIL reset_out_matrix: got %h want 0", out_matrix[31:0]); end
    start = 1'b0; selector = 1'b0; burstLen = '0; inValid = 1'b0; datsIn = '0;
    bufReady = 1'b0; matReady = 1'b0;
    rst_n = 1'b1;
    step();
    n_vec++; if (flags !== 5'b00000) begin n_err++; $display("FAIL reset_release_flags: got %b want 00000", flags); end
  endtask

  task automatic test_buffer_burst();
    selector = 1'b1; burstLen = 8'd4; start = 1'b1;
    step();
    start = 1'b0; bufReady = 1'b1; matReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      inValid = 1'b1; datsIn = beat(32'hA000_0000 + i);
      #1;
      n_vec++; if (flags !== {4'b1010, 1'b0} + {3'b000, (i > 0), 1'b0}) begin
        n_err++; $display("FAIL buf_flags_%0d: got %b want 101%0d0", i, flags, (i > 0));
      end
      if (i > 0) begin
        n_vec++; if (out_buffer !== beat(32'hA000_0000 + i - 1)) begin
          n_err++; $display("FAIL buf_data_%0d: got %h want %h", i - 1, out_buffer[31:0], 32'hA000_0000 + i - 1);
        end
        n_vec++; if (out_matrix !== beat(32'hA000_0000 + i - 1)) begin
          n_err++; $display("FAIL buf_mirror_%0d: got %h want %h", i - 1, out_matrix[31:0], 32'hA000_0000 + i - 1);
        end
      end
      step();
    end
    inValid = 1'b0;
    #1;
    n_vec++; if (flags !== 5'b10010) begin n_err++; $display("FAIL buf_last_flags: got %b want 10010", flags); end
    n_vec++; if (out_buffer !== beat(32'hA000_0003)) begin n_err++; $display("FAIL buf_data_3: got %h want a0000003", out_buffer[31:0]); end
    step();
    n_vec++; if (flags !== 5'b01000) begin n_err++; $display("FAIL buf_done: got %b want 01000", flags); end
    step();
    n_vec++; if (flags !== 5'b00000) begin n_err++; $display("FAIL buf_idle: got %b want 00000", flags); end
  endtask

  task automatic test_matrix_backpressure();
    bit pat [0:4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int tx = 0, rx = 0, n_done = 0, done_at = -1;
    bit was_stalled = 1'b0;
    logic [DATA_W-1:0] held = '0;
    selector = 1'b0; burstLen = 8'd3; start = 1'b1;
    step();
    start = 1'b0; bufReady = 1'b0;
    for (int c = 0; c < 12; c++) begin
      matReady = (c < 5) ? pat[c] : 1'b1;
      inValid  = (tx < 3);
      datsIn   = beat(32'hB000_0000 + tx);
      #1;
      if (was_stalled) begin
        n_vec++; if (out_matrix !== held) begin n_err++; $display("FAIL mat_hold_c%0d: got %h want %h", c, out_matrix[31:0], held[31:0]); end
      end
      if (done) begin n_done++; done_at = c; end
      if (matValid && !matReady) begin
        n_vec++; if (inReady !== 1'b0) begin n_err++; $display("FAIL mat_stall_ready_c%0d: got %b want 0", c, inReady); end
        held = out_matrix; was_stalled = 1'b1;
      end else begin
        was_stalled = 1'b0;
      end
      if (matValid && matReady) begin
        n_vec++; if (out_matrix !== beat(32'hB000_0000 + rx)) begin
          n_err++; $display("FAIL mat_data_%0d: got %h want %h", rx, out_matrix[31:0], 32'hB000_0000 + rx);
        end
        rx++;
      end
      n_vec++; if (bufValid !== 1'b0) begin n_err++; $display("FAIL mat_bufvalid_c%0d: got %b want 0", c, bufValid); end
      if (inValid && inReady) tx++;
      step();
    end
    inValid = 1'b0; matReady = 1'b0;
    n_vec++; if (rx !== 3) begin n_err++; $display("FAIL mat_rx_count: got %0d want 3", rx); end
    n_vec++; if (n_done !== 1) begin n_err++; $display("FAIL mat_done_count: got %0d want 1", n_done); end
    n_vec++; if (done_at !== 5) begin n_err++; $display("FAIL mat_done_cycle: got %0d want 5", done_at); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mat_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_zero_len();
    selector = 1'b1; burstLen = 8'd0; start = 1'b1; bufReady = 1'b1; matReady = 1'b1;
    #1;
    n_vec++; if (flags !== 5'b00000) begin n_err++; $display("FAIL zero_pre: got %b want 00000", flags); end
    step();
    start = 1'b0;
    #1;
    n_vec++; if (flags !== 5'b01000) begin n_err++; $display("FAIL zero_done: got %b want 01000", flags); end
    step();
    n_vec++; if (flags !== 5'b00000) begin n_err++; $display("FAIL zero_after: got %b want 00000", flags); end
  endtask

  task automatic test_start_during_run();
    selector = 1'b0; burstLen = 8'd2; start = 1'b1;
    step();
    inValid = 1'b1; datsIn = beat(32'hE000_0000);
    selector = 1'b1; burstLen = 8'd7; start = 1'b1;
    #1;
    n_vec++; if (flags !== 5'b10100) begin n_err++; $display("FAIL sdr_run: got %b want 10100", flags); end
    step();
    start = 1'b0; datsIn = beat(32'hE000_0001);
    #1;
    n_vec++; if (flags !== 5'b10101) begin n_err++; $display("FAIL sdr_beat0_flags: got %b want 10101", flags); end
    n_vec++; if (out_matrix !== beat(32'hE000_0000)) begin n_err++; $display("FAIL sdr_beat0: got %h want e0000000", out_matrix[31:0]); end
    step();
    inValid = 1'b0;
    #1;
    n_vec++; if (flags !== 5'b10001) begin n_err++; $display("FAIL sdr_beat1_flags: got %b want 10001", flags); end
    n_vec++; if (out_matrix !== beat(32'hE000_0001)) begin n_err++; $display("FAIL sdr_beat1: got %h want e0000001", out_matrix[31:0]); end
    step();
    n_vec++; if (flags !== 5'b01000) begin n_err++; $display("FAIL sdr_done: got %b want 01000", flags); end
    step();
    n_vec++; if (flags !== 5'b00000) begin n_err++; $display("FAIL sdr_idle: got %b want 00000", flags); end
  endtask

  task automatic test_selector_toggle();
    selector = 1'b1; burstLen = 8'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      selector = ~selector; inValid = 1'b1; datsIn = beat(32'hF000_0000 + i);
      #1;
      n_vec++; if (matValid !== 1'b0) begin n_err++; $display("FAIL tog_matvalid_%0d: got %b want 0", i, matValid); end
      if (i > 0) begin
        n_vec++; if (!bufValid || out_buffer !== beat(32'hF000_0000 + i - 1)) begin
          n_err++; $display("FAIL tog_data_%0d: got v=%b %h want v=1 %h", i - 1, bufValid, out_buffer[31:0], 32'hF000_0000 + i - 1);
        end
      end
      step();
    end
    selector = ~selector; inValid = 1'b0;
    #1;
    n_vec++; if (flags !== 5'b10010 || out_buffer !== beat(32'hF000_0002)) begin
      n_err++; $display("FAIL tog_last: got %b %h want 10010 f0000002", flags, out_buffer[31:0]);
    end
    step();
    n_vec++; if (flags !== 5'b01000) begin n_err++; $display("FAIL tog_done: got %b want 01000", flags); end
    step();
  endtask

  task automatic test_reset_mid_burst();
    selector = 1'b1; burstLen = 8'd5; start = 1'b1; bufReady = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      inValid = 1'b1; datsIn = beat(32'hC000_0000 + i);
      step();
    end
    #1;
    n_vec++; if (flags !== 5'b10110 || out_buffer !== beat(32'hC000_0002)) begin
      n_err++; $display("FAIL rmb_pre: got %b %h want 10110 c0000002", flags, out_buffer[31:0]);
    end
    rst_n = 1'b0; bufReady = 1'b0;
    step();
    n_vec++; if (flags !== 5'b00000) begin n_err++; $display("FAIL rmb_flags: got %b want 00000", flags); end
    n_vec++; if (out_buffer !== '0 || out_matrix !== '0) begin
      n_err++; $display("FAIL rmb_data: got %h/%h want 0/0", out_buffer[31:0], out_matrix[31:0]);
    end
    rst_n = 1'b1; inValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (flags !== 5'b00000) begin n_err++; $display("FAIL rmb_quiet_%0d: got %b want 00000", i, flags); end
    end
    selector = 1'b1; burstLen = 8'd1; start = 1'b1; bufReady = 1'b1;
    step();
    start = 1'b0; inValid = 1'b1; datsIn = beat(32'hD000_0000);
    #1;
    n_vec++; if (flags !== 5'b10100) begin n_err++; $display("FAIL rmb_new_run: got %b want 10100", flags); end
    step();
    inValid = 1'b0;
    #1;
    n_vec++; if (flags !== 5'b10010 || out_buffer !== beat(32'hD000_0000)) begin
      n_err++; $display("FAIL rmb_new_beat: got %b %h want 10010 d0000000", flags, out_buffer[31:0]);
    end
    step();
    n_vec++; if (flags !== 5'b01000) begin n_err++; $display("FAIL rmb_new_done: got %b want 01000", flags); end
    step();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; selector = 1'b0; burstLen = '0;
    inValid = 1'b0; datsIn = '0; bufReady = 1'b0; matReady = 1'b0;
    test_reset();
    test_buffer_burst();
    test_matrix_backpressure();
    test_zero_len();
    test_start_during_run();
    test_selector_toggle();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
